// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line constants and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LINE  = 1'b1;
    localparam int   PRESCALE_W = 6;

    // Parity over a zero-extended word; odd=1 selects odd parity.
    // Zero-extension does not change the XOR, so any width up to 64 fits.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - LSB-first shift register with bit counter for the UART TX path
module uart_tx_serializer #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [width-1:0] data_in,
    output logic             data_bit,
    output logic             done
);

    localparam int CNT_W = $clog2(width + 1);

    logic [width-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    // Load a fresh word, or hand out bit 0 and shift right, counting bits emitted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
        end else if (shift) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    assign data_bit = shift_reg[0];
    // bit_cnt counts bits already placed on the line; width means the last one is out.
    assign done     = (bit_cnt == CNT_W'(width));

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer; UART_TX_STOP2_EN selects two stop bits
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [width-1:0]      P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    tx_state_t             state;
    logic [PRESCALE_W-1:0] prescale_lat;
    logic [PRESCALE_W-1:0] prescale_cnt;
    logic                  par_en_lat;
    logic                  par_bit_lat;
`ifdef UART_TX_STOP2_EN
    logic                  stop_second;
`endif

    logic wrap;
    logic accept;
    logic ser_shift;
    logic ser_bit;
    logic ser_done;

    // End of the current bit time; meaningless in IDLE, where it is never used.
    assign wrap      = (prescale_cnt == prescale_lat - PRESCALE_W'(1));
    assign accept    = (state == IDLE) && DATA_VALID;
    // The first shift hands bit 0 to the line as START ends; no shift after the last data bit.
    assign ser_shift = wrap && ((state == START) || ((state == DATA) && !ser_done));

    uart_tx_serializer #(
        .width (width)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .shift    (ser_shift),
        .data_in  (P_DATA),
        .data_bit (ser_bit),
        .done     (ser_done)
    );

    // Frame FSM with prescale counter and registered line/busy outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            TX_OUT       <= IDLE_LINE;
            BUSY         <= 1'b0;
            prescale_cnt <= '0;
            prescale_lat <= '0;
            par_en_lat   <= 1'b0;
            par_bit_lat  <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_second  <= 1'b0;
`endif
        end else begin
            if (state == IDLE || wrap) begin
                prescale_cnt <= '0;
            end else begin
                prescale_cnt <= prescale_cnt + PRESCALE_W'(1);
            end

            case (state)
                IDLE: begin
                    if (DATA_VALID) begin
                        prescale_lat <= (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
                        par_en_lat   <= PAR_EN;
                        par_bit_lat  <= calc_parity(64'(P_DATA), PAR_TYP);
                        state        <= START;
                        TX_OUT       <= START_BIT;
                        BUSY         <= 1'b1;
                    end
                end
                START: begin
                    if (wrap) begin
                        state  <= DATA;
                        TX_OUT <= ser_bit;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        if (!ser_done) begin
                            TX_OUT <= ser_bit;
                        end else if (par_en_lat) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit_lat;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= STOP_BIT;
                        end
                    end
                end
                PARITY: begin
                    if (wrap) begin
                        state  <= STOP;
                        TX_OUT <= STOP_BIT;
                    end
                end
                STOP: begin
                    if (wrap) begin
`ifdef UART_TX_STOP2_EN
                        if (!stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            state       <= IDLE;
                            BUSY        <= 1'b0;
                        end
`else
                        state <= IDLE;
                        BUSY  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= IDLE_LINE;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer against a frame-level model
module tb_uart_tx_framer;

    localparam int W = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_EXTRA = 1;
`else
    localparam int STOP_EXTRA = 0;
`endif

    logic         CLK_tb = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         DATA_VALID = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [5:0]   PRESCALE = 6'd1;
    logic         TX_OUT;
    logic         BUSY;

    int n_checks = 0;
    int n_pass = 0;

    uart_tx_framer #(.width(W)) dut (
        .CLK        (CLK_tb),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK_tb = ~CLK_tb;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Number of bit slots in one frame
    function automatic int frame_bits(input bit pe);
        return 1 + W + int'(pe) + 1 + STOP_EXTRA;
    endfunction

    // Line level of bit slot k of a frame
    function automatic logic frame_bit(input logic [W-1:0] d, input bit pe, input bit pt, input int k);
        if (k == 0) return 1'b0;
        if (k <= W) return d[k-1];
        if (k == W + 1 && pe) return (^d) ^ pt;
        return 1'b1;
    endfunction

    // Frame-level model: position within the current frame, expected outputs after each edge
    bit           m_active = 0;
    int           m_idx = 0;
    int           m_p = 1;
    logic [W-1:0] m_d = '0;
    bit           m_pe = 0;
    bit           m_pt = 0;
    logic         m_tx = 1'b1;
    logic         m_busy = 1'b0;

    always @(posedge CLK_tb) begin
        if (RST) begin
            m_active = 0;
        end else if (m_active) begin
            m_idx++;
            if (m_idx == frame_bits(m_pe) * m_p) m_active = 0;
        end else if (DATA_VALID) begin
            m_active = 1;
            m_idx = 0;
            m_d = P_DATA;
            m_pe = PAR_EN;
            m_pt = PAR_TYP;
            m_p = (PRESCALE == 0) ? 1 : int'(PRESCALE);
        end
        m_tx = m_active ? frame_bit(m_d, m_pe, m_pt, m_idx / m_p) : 1'b1;
        m_busy = m_active;
    end

    // Compare every cycle, away from the active edge
    always @(negedge CLK_tb) begin
        check("tx_out", int'(TX_OUT), int'(m_tx));
        check("busy", int'(BUSY), int'(m_busy));
    end

    task automatic send(input logic [W-1:0] d, input bit pe, input bit pt, input logic [5:0] ps);
        @(negedge CLK_tb);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        PRESCALE = ps;
        DATA_VALID = 1'b1;
        @(negedge CLK_tb);
        DATA_VALID = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (BUSY && n < 5000) begin
            n++;
            @(negedge CLK_tb);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (BUSY && t < 5000) begin
            t++;
            @(negedge CLK_tb);
        end
        check(name, int'(BUSY), 0);
    endtask

    initial begin
        int n;
        logic [10:0] seq;

        // Pin the model with hand-computed frames
        check("model_len_t1", frame_bits(1) * 8, 88 + 8 * STOP_EXTRA);
        check("model_len_t3", frame_bits(0) * 32, 320 + 32 * STOP_EXTRA);
        seq = '0;
        for (int k = 0; k < 11; k++) seq = {seq[9:0], frame_bit(8'hAA, 1, 0, k)};
        check("model_seq_aa_even", int'(seq), int'(11'b00101010101));
        check("model_par_aa_odd", int'(frame_bit(8'hAA, 1, 1, 9)), 1);
        check("model_par_ea_even", int'(frame_bit(8'hEA, 1, 0, 9)), 1);

        repeat (3) @(negedge CLK_tb);
        check("reset_tx", int'(TX_OUT), 1);
        check("reset_busy", int'(BUSY), 0);
        RST = 1'b0;
        @(negedge CLK_tb);

        // Directed frames with known busy lengths
        send(8'hAA, 1, 0, 6'd8);
        measure_busy(n);
        check("t1_busy_len", n, 88 + 8 * STOP_EXTRA);
        send(8'hAA, 1, 1, 6'd16);
        measure_busy(n);
        check("t2_busy_len", n, 176 + 16 * STOP_EXTRA);
        send(8'hAA, 0, 0, 6'd32);
        measure_busy(n);
        check("t3_busy_len", n, 320 + 32 * STOP_EXTRA);

        // Mid-frame request is dropped; request on the cycle busy falls is taken
        send(8'hAA, 1, 0, 6'd8);
        repeat (38) @(negedge CLK_tb);
        P_DATA = 8'h55;
        DATA_VALID = 1'b1;
        @(negedge CLK_tb);
        DATA_VALID = 1'b0;
        wait_idle("t4_first_done");
        P_DATA = 8'hEA;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        PRESCALE = 6'd8;
        DATA_VALID = 1'b1;
        @(negedge CLK_tb);
        DATA_VALID = 1'b0;
        check("t4_start_busy", int'(BUSY), 1);
        check("t4_start_tx", int'(TX_OUT), 0);
        repeat (72) @(negedge CLK_tb);
        check("t4_parity", int'(TX_OUT), 1);
        wait_idle("t4_second_done");

        // Reset in the data phase, then a clean frame
        send(8'hAA, 1, 0, 6'd8);
        repeat (40) @(negedge CLK_tb);
        RST = 1'b1;
        @(negedge CLK_tb);
        RST = 1'b0;
        check("t5_rst_tx", int'(TX_OUT), 1);
        check("t5_rst_busy", int'(BUSY), 0);
        send(8'h3C, 1, 1, 6'd4);
        measure_busy(n);
        check("t5_busy_len", n, 44 + 4 * STOP_EXTRA);

        // PRESCALE 0 and 1 run one bit per clock
        send(8'h96, 0, 0, 6'd0);
        measure_busy(n);
        check("p0_busy_len", n, 10 + STOP_EXTRA);
        send(8'h96, 1, 1, 6'd1);
        measure_busy(n);
        check("p1_busy_len", n, 11 + STOP_EXTRA);

        // Random traffic: inputs churn every cycle, occasional resets
        for (int c = 0; c < 6000; c++) begin
            @(negedge CLK_tb);
            RST = ($urandom_range(0, 799) == 0);
            DATA_VALID = ($urandom_range(0, 7) == 0);
            P_DATA = W'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
            PRESCALE = ($urandom_range(0, 29) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
        end
        @(negedge CLK_tb);
        RST = 1'b0;
        DATA_VALID = 1'b0;
        wait_idle("final_idle");
        repeat (2) @(negedge CLK_tb);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Serial UART transmitter. It is the upstream counterpart of the UART receiver and drives the line that the receiver samples.
- Accepts one parallel word per DATA_VALID pulse.
- Frames the word as start bit, data bits (LSB first), optional parity bit and stop bit.
- Shifts the frame out on TX_OUT, holding each bit for PRESCALE clocks, so the same PRESCALE/PAR_EN/PAR_TYP settings match the receiver.
- Lives in the TX clock domain and is fed by the system controller through the data synchroniser.

Parameters:
width, 8, number of data bits per frame.

Ports:
CLK  in  1  TX-domain clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
P_DATA  in  width  parallel word to send; sampled only on acceptance.
DATA_VALID  in  1  request to send P_DATA.
PAR_EN  in  1  1 = append parity bit.
PAR_TYP  in  1  0 = even, 1 = odd parity.
PRESCALE  in  6  clocks per bit; legal 1..63; 0 treated as 1.
TX_OUT  out  1  serial line, idle high.
BUSY  out  1  high while a frame is in flight.

Behaviour:
- Reset: the synchronous, active-high reset applies on the next CLK edge.
  - TX_OUT=1, BUSY=0, state=IDLE; bit and prescale counters = 0; shift register cleared.
  - Reset mid-frame abandons the frame and leaves the line high.
  - RST wins over a simultaneous DATA_VALID.
- Outputs: TX_OUT and BUSY are registered; no combinational path from any input.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - Happens only in IDLE, when DATA_VALID=1 at a rising edge.
  - On that edge, latch P_DATA, PAR_EN, PAR_TYP and PRESCALE (0 mapped to 1), and move to START.
  - Latched configuration holds for the whole frame; input changes mid-frame have no effect.
  - DATA_VALID while BUSY=1 is ignored (dropped, not queued).
- Latency: TX_OUT goes 0 and BUSY goes 1 on the clock after the accepting edge.
- Bit timing:
  - A 6-bit prescale counter counts 0..PRESCALE_latched-1.
  - Each bit is held for exactly PRESCALE_latched cycles.
  - State and bit advance when the counter wraps.
- START: TX_OUT=0 for one bit time, then DATA.
- DATA:
  - Outputs shift_reg[0], then shifts right.
  - A bit counter runs 0..width-1.
  - After the width-th bit: go to PARITY if PAR_EN_latched, else STOP.
- PARITY: TX_OUT = (XOR of latched data) XOR PAR_TYP_latched. Parity is computed once at acceptance.
- STOP: TX_OUT=1 for one bit time, then IDLE, with BUSY=0 from the same edge.
- Frame length: (1 + width + PAR_EN + 1) * PRESCALE clocks; e.g. 88 for width=8, parity on, PRESCALE=8.
- Minimum inter-frame gap: 1 idle cycle, since acceptance happens only in IDLE.
- PRESCALE=1: one bit per clock; the counter stays 0 and every cycle advances.

Optional Feature:
UART_TX_STOP2_EN
- Defined: STOP lasts two bit times (TX_OUT=1 for 2*PRESCALE clocks); frame is one bit longer.
- Undefined: single stop bit as above.
- The receiver's stop check accepts either setting.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=0, STOP_BIT=1, IDLE_LINE=1, PRESCALE_W=6;
  - a parity function shared with the receiver's parity check.
- One sub-module, uart_tx_serializer: shift register plus bit counter, with load, shift and done signals.
- The FSM, prescale counter and output mux stay in the top module.

Test Plan:
1. P_DATA=8'hAA, PAR_EN=1, PAR_TYP=0, PRESCALE=8, 1-cycle DATA_VALID -> TX_OUT sequence 0,0,1,0,1,0,1,0,1,0,1, each held 8 clocks. BUSY high exactly 88 clocks, starting the cycle after the pulse.
2. Same data with PAR_TYP=1, PRESCALE=16 -> parity bit 1, bits held 16 clocks, BUSY high 176 clocks.
3. P_DATA=8'hAA, PAR_EN=0, PRESCALE=32 -> 10-bit frame (no parity slot), stop bit starts at clock 288, BUSY high 320 clocks.
4. DATA_VALID re-asserted with 8'h55 at clock 40 of a frame -> ignored; the frame in flight carries 0xAA. DATA_VALID again the cycle BUSY falls -> 0xEA frame (parity on, PAR_TYP=0) starts the next cycle with parity bit 1.
5. RST asserted during the DATA state -> on the next edge TX_OUT=1, BUSY=0. A new DATA_VALID afterwards sends a clean full frame.
6. Loopback: TX_OUT wired to the UART receiver for all PRESCALE ∈ {8,16,32} × {even, odd, none} -> receiver P_DATA equals the sent word, PAR_ERR=0, STP_ERR=0. Repeat with UART_TX_STOP2_EN defined.
